fp_mean_cov_axil_regfile: RTL and testbench
===========================================

// Module: fp_mean_cov_axil_regfile
// PURPOSE
//  Parametrised AXI4-Lite slave register file for the FP mean/covariance coprocessor. It generalises
//  the fixed 4-register slave to N_RESULTS read-only result words and adds a self-clearing START
//  pulse, sticky W1C status bits, a level IRQ, and a backpressured sample-push register.
//  Sits between the PS interconnect and the mean/cov datapath core.
// PARAMETERS
//  C_S_AXI_DATA_WIDTH  32  AXI data width; fixed at 32 (WSTRB is 4 bits)
//  C_S_AXI_ADDR_WIDTH  6   byte address width; 2**(W-2) >= 4+N_RESULTS
//  N_RESULTS           8   read-only result words from the core (1..2**(W-2)-4)
// PORTS
//  ACLK           in   1          clock
//  ARESETN        in   1          asynchronous active-low reset
//  S_AXI_AWADDR   in   ADDR_W     write address (AWPROT accepted, ignored)
//  S_AXI_AWPROT   in   3          ignored
//  S_AXI_AWVALID/AWREADY  in/out 1 write-address handshake
//  S_AXI_WDATA    in   32         write data
//  S_AXI_WSTRB    in   4          byte enables
//  S_AXI_WVALID/WREADY    in/out 1 write-data handshake
//  S_AXI_BRESP    out  2          00 OKAY, 10 SLVERR
//  S_AXI_BVALID/BREADY    out/in 1 write-response handshake
//  S_AXI_ARADDR   in   ADDR_W     read address; S_AXI_ARPROT in 3, ignored
//  S_AXI_ARVALID/ARREADY  in/out 1 read-address handshake
//  S_AXI_RDATA    out  32         read data
//  S_AXI_RRESP    out  2          00 OKAY, 10 SLVERR
//  S_AXI_RVALID/RREADY    out/in 1 read-data handshake
//  core_start     out  1          1-cycle start pulse
//  core_n_samples out  32         CFG register contents
//  sample_data    out  32         pushed sample
//  sample_valid/sample_ready out/in 1 sample stream handshake
//  core_busy      in   1          core busy level
//  core_done      in   1          1-cycle completion pulse
//  core_result    in   32*N_RESULTS  result words, word k at [32k+31:32k]
//  irq            out  1          registered interrupt level
// BEHAVIOUR
//  Word map (addr[W-1:2]): 0 CTRL{[2]IRQ_EN rw,[0]START wo}; 1 STATUS{[2]ERR w1c,[1]DONE w1c,[0]BUSY ro};
//   2 CFG rw; 3 SAMPLE wo (reads 0); 4..3+N_RESULTS RESULT ro; other words: SLVERR, RDATA=0, no effect.
//  Reset: all READY/VALID low, BRESP/RRESP/RDATA 0, CTRL/CFG/STATUS 0, core_start 0, sample_valid 0,
//   sample_data 0, irq 0; in-flight AXI transactions discarded.
//  Write path: AW and W latched independently; AWREADY=!aw_held&&!BVALID, WREADY=!w_held&&!BVALID.
//   Commit when both held and (target!=SAMPLE or !sample_valid or sample_ready); BVALID next cycle,
//   held until BREADY. Min latency: AW+W same cycle -> BVALID next cycle. No write outstanding >1.
//  WSTRB: RW regs update only enabled bytes; START/W1C act only if byte 0 enabled; SAMPLE needs all 4
//   strobes, otherwise SLVERR and no push. Write to RO RESULT: SLVERR, no effect.
//  START: write 1 with core_busy=0 -> core_start high exactly one cycle after commit; with core_busy=1
//   -> no pulse, STATUS.ERR set. CTRL[0] always reads 0.
//  SAMPLE: commit loads sample_data, sets sample_valid; cleared on sample_valid&&sample_ready unless a
//   new commit same cycle (then stays 1 with new data). Full slot stalls commit, so BVALID is delayed.
//  STATUS: DONE set by core_done; ERR by blocked START; W1C clears; set and clear same cycle -> set wins.
//   BUSY reflects core_busy live. irq <= IRQ_EN && DONE (one-cycle registered lag).
//  Read path: ARREADY=!RVALID; RDATA/RRESP captured at AR handshake (RESULT = live core_result snapshot),
//   RVALID next cycle, held with stable RDATA until RREADY. Reads and writes fully independent.
// STRUCTURE
//  Package fp_mean_cov_pkg: register word-index constants, CTRL/STATUS bit positions, RESP_OKAY/SLVERR.
//  One sub-module fp_mean_cov_axil_wr_ch: AW/W capture latches + commit/B-response FSM (IDLE, HOLD, RESP).
//  Read channel, register bank, sample slot and IRQ inline.
// TESTING
//  AW,W same cycle to CFG 0x12345678, then read 0x08 -> BVALID 1 cycle later OKAY; RDATA 0x12345678.
//  W 3 cycles before AW, WSTRB=0011 data 0xFFFFFFFF to CFG=0 -> CFG 0x0000FFFF, single BVALID.
//  Write CTRL 0x5, core_busy=0 -> core_start 1 cycle; core_done pulse -> STATUS 0x2, irq 1; W1C 0x2
//   -> STATUS 0, irq 0. Repeat with core_busy=1 -> no pulse, STATUS 0x5.
//  sample_ready=0, write SAMPLE 0xA then 0xB -> first OKAY, second BVALID stalls; ready=1 -> 0xA taken,
//   then 0xB presented; BVALID released.
//  Read 0x3C (beyond map, N_RESULTS=8) and write RESULT[0] -> SLVERR, RDATA 0, result unchanged.
//  ARESETN low mid-write with AW held, BREADY=0 -> all outputs reset values; following write completes.

Source files
------------

// File: rtl/fp_mean_cov_pkg.sv
// Shared constants for the FP mean/covariance coprocessor register file:
// register word indices, CTRL/STATUS bit positions, AXI response codes and
// the write-channel state encoding.
package fp_mean_cov_pkg;

    localparam int WORD_CTRL    = 0;
    localparam int WORD_STATUS  = 1;
    localparam int WORD_CFG     = 2;
    localparam int WORD_SAMPLE  = 3;
    localparam int WORD_RESULT0 = 4;

    localparam int CTRL_START_BIT  = 0;
    localparam int CTRL_IRQ_EN_BIT = 2;

    localparam int STATUS_BUSY_BIT = 0;
    localparam int STATUS_DONE_BIT = 1;
    localparam int STATUS_ERR_BIT  = 2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] WR_IDLE = 2'd0;
    localparam logic [1:0] WR_HOLD = 2'd1;
    localparam logic [1:0] WR_RESP = 2'd2;

endpackage

// File: rtl/fp_mean_cov_axil_wr_ch.sv
// AXI4-Lite write channel: independent AW/W capture latches and the
// commit / B-response sequencing. An address or data beat arriving in the
// same cycle as its partner commits immediately, so BVALID follows one cycle
// after a combined AW+W handshake. The parent decides when a commit may
// proceed (commit_ok) and what response it earns (commit_resp).
module fp_mean_cov_axil_wr_ch
    import fp_mean_cov_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_W-1:0]     aw_addr,
    input  logic                  aw_valid,
    output logic                  aw_ready,
    input  logic [DATA_W-1:0]     w_data,
    input  logic [DATA_W/8-1:0]   w_strb,
    input  logic                  w_valid,
    output logic                  w_ready,
    output logic [1:0]            b_resp,
    output logic                  b_valid,
    input  logic                  b_ready,
    input  logic                  commit_ok,
    input  logic [1:0]            commit_resp,
    output logic                  commit,
    output logic [ADDR_W-1:0]     cm_addr,
    output logic [DATA_W-1:0]     cm_data,
    output logic [DATA_W/8-1:0]   cm_strb
);

    logic [1:0]          state;
    logic                active;
    logic                aw_held;
    logic                w_held;
    logic [ADDR_W-1:0]   aw_addr_q;
    logic [DATA_W-1:0]   w_data_q;
    logic [DATA_W/8-1:0] w_strb_q;
    logic [1:0]          b_resp_q;
    logic                aw_hs;
    logic                w_hs;
    logic                aw_have;
    logic                w_have;

    assign b_valid  = (state == WR_RESP);
    assign b_resp   = b_resp_q;
    assign aw_ready = active && !aw_held && !b_valid;
    assign w_ready  = active && !w_held && !b_valid;

    assign aw_hs   = aw_valid && aw_ready;
    assign w_hs    = w_valid && w_ready;
    assign aw_have = aw_held || aw_hs;
    assign w_have  = w_held || w_hs;

    assign cm_addr = aw_held ? aw_addr_q : aw_addr;
    assign cm_data = w_held ? w_data_q : w_data;
    assign cm_strb = w_held ? w_strb_q : w_strb;
    assign commit  = aw_have && w_have && commit_ok && (state != WR_RESP);

    // Capture AW/W beats, commit once both are present, then hold B until accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= WR_IDLE;
            active    <= 1'b0;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            b_resp_q  <= RESP_OKAY;
        end else begin
            active <= 1'b1;
            case (state)
                WR_IDLE, WR_HOLD: begin
                    if (aw_hs) begin
                        aw_addr_q <= aw_addr;
                    end
                    if (w_hs) begin
                        w_data_q <= w_data;
                        w_strb_q <= w_strb;
                    end
                    if (commit) begin
                        state    <= WR_RESP;
                        aw_held  <= 1'b0;
                        w_held   <= 1'b0;
                        b_resp_q <= commit_resp;
                    end else begin
                        if (aw_hs) begin
                            aw_held <= 1'b1;
                        end
                        if (w_hs) begin
                            w_held <= 1'b1;
                        end
                        state <= (aw_have || w_have) ? WR_HOLD : WR_IDLE;
                    end
                end
                WR_RESP: begin
                    if (b_ready) begin
                        state <= WR_IDLE;
                    end
                end
                default: begin
                    state <= WR_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/fp_mean_cov_axil_regfile.sv
// AXI4-Lite slave register file for the FP mean/covariance coprocessor.
// Holds CTRL (start pulse, IRQ enable), STATUS (live busy, sticky W1C done
// and error), CFG, a backpressured one-entry SAMPLE slot and N_RESULTS
// read-only result words taken live from the core.
module fp_mean_cov_axil_regfile
    import fp_mean_cov_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int N_RESULTS          = 8
) (
    input  logic                                      ACLK,
    input  logic                                      ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]             S_AXI_AWADDR,
    input  logic [2:0]                                S_AXI_AWPROT,
    input  logic                                      S_AXI_AWVALID,
    output logic                                      S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]             S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]           S_AXI_WSTRB,
    input  logic                                      S_AXI_WVALID,
    output logic                                      S_AXI_WREADY,
    output logic [1:0]                                S_AXI_BRESP,
    output logic                                      S_AXI_BVALID,
    input  logic                                      S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]             S_AXI_ARADDR,
    input  logic [2:0]                                S_AXI_ARPROT,
    input  logic                                      S_AXI_ARVALID,
    output logic                                      S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]             S_AXI_RDATA,
    output logic [1:0]                                S_AXI_RRESP,
    output logic                                      S_AXI_RVALID,
    input  logic                                      S_AXI_RREADY,
    output logic                                      core_start,
    output logic [C_S_AXI_DATA_WIDTH-1:0]             core_n_samples,
    output logic [C_S_AXI_DATA_WIDTH-1:0]             sample_data,
    output logic                                      sample_valid,
    input  logic                                      sample_ready,
    input  logic                                      core_busy,
    input  logic                                      core_done,
    input  logic [C_S_AXI_DATA_WIDTH*N_RESULTS-1:0]   core_result,
    output logic                                      irq
);

    localparam int DW     = C_S_AXI_DATA_WIDTH;
    localparam int AW     = C_S_AXI_ADDR_WIDTH;
    localparam int WORD_W = AW - 2;

    localparam logic [WORD_W-1:0] W_CTRL   = WORD_W'(WORD_CTRL);
    localparam logic [WORD_W-1:0] W_STATUS = WORD_W'(WORD_STATUS);
    localparam logic [WORD_W-1:0] W_CFG    = WORD_W'(WORD_CFG);
    localparam logic [WORD_W-1:0] W_SAMPLE = WORD_W'(WORD_SAMPLE);

    logic              commit;
    logic              commit_ok;
    logic [1:0]        commit_resp;
    logic [AW-1:0]     cm_addr;
    logic [DW-1:0]     cm_data;
    logic [DW/8-1:0]   cm_strb;
    logic [WORD_W-1:0] cm_word;
    logic [WORD_W-1:0] ar_word;

    logic              irq_en;
    logic              status_done;
    logic              status_err;
    logic [DW-1:0]     cfg;
    logic              start_req;
    logic              w1c_done;
    logic              w1c_err;
    logic              sample_push;
    logic              wr_ctrl;
    logic              wr_status;
    logic              wr_cfg;

    logic              rd_active;
    logic              ar_hs;
    logic [DW-1:0]     rd_val;
    logic [1:0]        rd_resp;
    logic              unused_ok;

    fp_mean_cov_axil_wr_ch #(
        .ADDR_W (AW),
        .DATA_W (DW)
    ) u_wr_ch (
        .clk         (ACLK),
        .rst_n       (ARESETN),
        .aw_addr     (S_AXI_AWADDR),
        .aw_valid    (S_AXI_AWVALID),
        .aw_ready    (S_AXI_AWREADY),
        .w_data      (S_AXI_WDATA),
        .w_strb      (S_AXI_WSTRB),
        .w_valid     (S_AXI_WVALID),
        .w_ready     (S_AXI_WREADY),
        .b_resp      (S_AXI_BRESP),
        .b_valid     (S_AXI_BVALID),
        .b_ready     (S_AXI_BREADY),
        .commit_ok   (commit_ok),
        .commit_resp (commit_resp),
        .commit      (commit),
        .cm_addr     (cm_addr),
        .cm_data     (cm_data),
        .cm_strb     (cm_strb)
    );

    assign cm_word   = cm_addr[AW-1:2];
    assign ar_word   = S_AXI_ARADDR[AW-1:2];
    assign unused_ok = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_ARADDR[1:0], cm_addr[1:0]};

    // A sample write waits while the slot is full and not being drained this cycle
    assign commit_ok = (cm_word != W_SAMPLE) || !sample_valid || sample_ready;

    assign wr_ctrl     = commit && (cm_word == W_CTRL);
    assign wr_status   = commit && (cm_word == W_STATUS);
    assign wr_cfg      = commit && (cm_word == W_CFG);
    assign start_req   = wr_ctrl && cm_strb[0] && cm_data[CTRL_START_BIT];
    assign w1c_done    = wr_status && cm_strb[0] && cm_data[STATUS_DONE_BIT];
    assign w1c_err     = wr_status && cm_strb[0] && cm_data[STATUS_ERR_BIT];
    assign sample_push = commit && (cm_word == W_SAMPLE) && (&cm_strb);

    assign core_n_samples = cfg;

    // Write response: only CTRL, STATUS, CFG and fully-strobed SAMPLE are accepted
    always_comb begin
        commit_resp = RESP_SLVERR;
        case (cm_word)
            W_CTRL, W_STATUS, W_CFG: commit_resp = RESP_OKAY;
            W_SAMPLE:                commit_resp = (&cm_strb) ? RESP_OKAY : RESP_SLVERR;
            default:                 commit_resp = RESP_SLVERR;
        endcase
    end

    // Control and status: start pulse or blocked-start error, sticky W1C bits with set priority, registered IRQ
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            irq_en      <= 1'b0;
            status_done <= 1'b0;
            status_err  <= 1'b0;
            core_start  <= 1'b0;
            irq         <= 1'b0;
        end else begin
            core_start <= start_req && !core_busy;
            if (wr_ctrl && cm_strb[0]) begin
                irq_en <= cm_data[CTRL_IRQ_EN_BIT];
            end
            status_done <= (status_done && !w1c_done) || core_done;
            status_err  <= (status_err && !w1c_err) || (start_req && core_busy);
            irq         <= irq_en && status_done;
        end
    end

    // CFG register with per-byte write enables
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            cfg <= '0;
        end else begin
            for (int b = 0; b < DW/8; b++) begin
                if (wr_cfg && cm_strb[b]) begin
                    cfg[8*b +: 8] <= cm_data[8*b +: 8];
                end
            end
        end
    end

    // One-entry sample slot; a push in the same cycle as a drain keeps the slot full
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            sample_data  <= '0;
            sample_valid <= 1'b0;
        end else if (sample_push) begin
            sample_data  <= cm_data;
            sample_valid <= 1'b1;
        end else if (sample_valid && sample_ready) begin
            sample_valid <= 1'b0;
        end
    end

    assign S_AXI_ARREADY = rd_active && !S_AXI_RVALID;
    assign ar_hs         = S_AXI_ARVALID && S_AXI_ARREADY;

    // Read decode; result words are a live view of the core outputs
    always_comb begin
        rd_val  = '0;
        rd_resp = RESP_OKAY;
        case (ar_word)
            W_CTRL: begin
                rd_val[CTRL_IRQ_EN_BIT] = irq_en;
            end
            W_STATUS: begin
                rd_val[STATUS_BUSY_BIT] = core_busy;
                rd_val[STATUS_DONE_BIT] = status_done;
                rd_val[STATUS_ERR_BIT]  = status_err;
            end
            W_CFG: begin
                rd_val = cfg;
            end
            W_SAMPLE: begin
                rd_val = '0;
            end
            default: begin
                rd_resp = RESP_SLVERR;
                for (int k = 0; k < N_RESULTS; k++) begin
                    if (ar_word == WORD_W'(WORD_RESULT0 + k)) begin
                        rd_val  = core_result[DW*k +: DW];
                        rd_resp = RESP_OKAY;
                    end
                end
            end
        endcase
    end

    // Read channel: capture data at the AR handshake and hold it until RREADY
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rd_active    <= 1'b0;
            S_AXI_RDATA  <= '0;
            S_AXI_RRESP  <= RESP_OKAY;
            S_AXI_RVALID <= 1'b0;
        end else begin
            rd_active <= 1'b1;
            if (ar_hs) begin
                S_AXI_RDATA  <= rd_val;
                S_AXI_RRESP  <= rd_resp;
                S_AXI_RVALID <= 1'b1;
            end else if (S_AXI_RVALID && S_AXI_RREADY) begin
                S_AXI_RVALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fp_mean_cov_axil_regfile.sv
// Directed self-checking bench for fp_mean_cov_axil_regfile. Inputs are
// driven and outputs sampled on the falling clock edge.
module tb_fp_mean_cov_axil_regfile;

    localparam int AW = 6;
    localparam int NR = 8;

    logic              aclk = 1'b0;
    logic              aresetn;
    logic [AW-1:0]     awaddr;
    logic [2:0]        awprot;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [AW-1:0]     araddr;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;
    logic              core_start;
    logic [31:0]       core_n_samples;
    logic [31:0]       sample_data;
    logic              sample_valid;
    logic              sample_ready;
    logic              core_busy;
    logic              core_done;
    logic [32*NR-1:0]  core_result;
    logic              irq;

    int n_checks = 0;
    int n_pass   = 0;
    int start_cnt = 0;
    int start_with_b = 0;

    always #5 aclk = ~aclk;

    fp_mean_cov_axil_regfile #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (AW),
        .N_RESULTS          (NR)
    ) dut (
        .ACLK           (aclk),
        .ARESETN        (aresetn),
        .S_AXI_AWADDR   (awaddr),
        .S_AXI_AWPROT   (awprot),
        .S_AXI_AWVALID  (awvalid),
        .S_AXI_AWREADY  (awready),
        .S_AXI_WDATA    (wdata),
        .S_AXI_WSTRB    (wstrb),
        .S_AXI_WVALID   (wvalid),
        .S_AXI_WREADY   (wready),
        .S_AXI_BRESP    (bresp),
        .S_AXI_BVALID   (bvalid),
        .S_AXI_BREADY   (bready),
        .S_AXI_ARADDR   (araddr),
        .S_AXI_ARPROT   (arprot),
        .S_AXI_ARVALID  (arvalid),
        .S_AXI_ARREADY  (arready),
        .S_AXI_RDATA    (rdata),
        .S_AXI_RRESP    (rresp),
        .S_AXI_RVALID   (rvalid),
        .S_AXI_RREADY   (rready),
        .core_start     (core_start),
        .core_n_samples (core_n_samples),
        .sample_data    (sample_data),
        .sample_valid   (sample_valid),
        .sample_ready   (sample_ready),
        .core_busy      (core_busy),
        .core_done      (core_done),
        .core_result    (core_result),
        .irq            (irq)
    );

    // Count start-pulse cycles and how many of them line up with BVALID
    always @(negedge aclk) begin
        if (core_start) start_cnt++;
        if (core_start && bvalid) start_with_b++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic writeReg(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_delay, output logic [1:0] resp, output int lat);
        logic aw_hit;
        logic w_hit;
        bit   aw_up;
        int   cyc;
        @(negedge aclk);
        awaddr  = addr;
        wdata   = data;
        wstrb   = strb;
        wvalid  = 1'b1;
        awvalid = (aw_delay == 0);
        aw_up   = (aw_delay == 0);
        bready  = 1'b1;
        cyc     = 0;
        while (!bvalid && cyc < 50) begin
            aw_hit = awvalid && awready;
            w_hit  = wvalid && wready;
            @(negedge aclk);
            cyc++;
            if (aw_hit) awvalid = 1'b0;
            if (w_hit) wvalid = 1'b0;
            if (!aw_up && cyc >= aw_delay) begin
                awvalid = 1'b1;
                aw_up   = 1'b1;
            end
        end
        checkOutput("wr_bvalid_seen", 32'(bvalid), 32'd1);
        resp = bresp;
        lat  = cyc;
        @(negedge aclk);
        awvalid = 1'b0;
        wvalid  = 1'b0;
    endtask

    task automatic readReg(input logic [AW-1:0] addr, output logic [31:0] data, output logic [1:0] resp);
        logic ar_hit;
        int   cyc;
        @(negedge aclk);
        araddr  = addr;
        arvalid = 1'b1;
        rready  = 1'b1;
        cyc     = 0;
        while (!rvalid && cyc < 50) begin
            ar_hit = arvalid && arready;
            @(negedge aclk);
            cyc++;
            if (ar_hit) arvalid = 1'b0;
        end
        checkOutput("rd_rvalid_seen", 32'(rvalid), 32'd1);
        data = rdata;
        resp = rresp;
        @(negedge aclk);
        arvalid = 1'b0;
    endtask

    task automatic pulseDone();
        @(negedge aclk);
        core_done = 1'b1;
        @(negedge aclk);
        core_done = 1'b0;
    endtask

    task automatic applyStimulus();
        logic [31:0] rd;
        logic [1:0]  rs;
        logic [1:0]  wr;
        int          lat;
        int          s0;
        int          sb;

        // Reset state
        @(negedge aclk);
        checkOutput("rst_awready", 32'(awready), 32'd0);
        checkOutput("rst_arready", 32'(arready), 32'd0);
        checkOutput("rst_bvalid", 32'(bvalid), 32'd0);
        checkOutput("rst_rvalid", 32'(rvalid), 32'd0);
        checkOutput("rst_irq", 32'(irq), 32'd0);
        aresetn = 1'b1;
        repeat (2) @(negedge aclk);
        readReg(6'h00, rd, rs);
        checkOutput("rst_ctrl", rd, 32'h0);
        readReg(6'h04, rd, rs);
        checkOutput("rst_status", rd, 32'h0);
        readReg(6'h08, rd, rs);
        checkOutput("rst_cfg", rd, 32'h0);
        checkOutput("rst_cfg_resp", 32'(rs), 32'd0);

        // CFG write with AW and W together
        writeReg(6'h08, 32'h12345678, 4'hF, 0, wr, lat);
        checkOutput("cfg_resp", 32'(wr), 32'd0);
        checkOutput("cfg_latency", lat, 32'd1);
        checkOutput("cfg_nsamples", core_n_samples, 32'h12345678);
        readReg(6'h08, rd, rs);
        checkOutput("cfg_readback", rd, 32'h12345678);

        // W three cycles ahead of AW, partial strobes
        writeReg(6'h08, 32'h0, 4'hF, 0, wr, lat);
        writeReg(6'h08, 32'hFFFFFFFF, 4'b0011, 3, wr, lat);
        checkOutput("wfirst_resp", 32'(wr), 32'd0);
        checkOutput("wfirst_latency", lat, 32'd4);
        checkOutput("wfirst_single_b", 32'(bvalid), 32'd0);
        readReg(6'h08, rd, rs);
        checkOutput("wfirst_cfg", rd, 32'h0000FFFF);

        // START with core idle, then DONE, IRQ and W1C
        core_busy = 1'b0;
        s0 = start_cnt;
        sb = start_with_b;
        writeReg(6'h00, 32'h5, 4'hF, 0, wr, lat);
        checkOutput("start_pulse_cnt", start_cnt - s0, 32'd1);
        checkOutput("start_pulse_timing", start_with_b - sb, 32'd1);
        readReg(6'h00, rd, rs);
        checkOutput("ctrl_read", rd, 32'h4);
        @(negedge aclk);
        core_done = 1'b1;
        @(negedge aclk);
        core_done = 1'b0;
        checkOutput("irq_lag", 32'(irq), 32'd0);
        @(negedge aclk);
        checkOutput("irq_set", 32'(irq), 32'd1);
        readReg(6'h04, rd, rs);
        checkOutput("status_done", rd, 32'h2);
        writeReg(6'h04, 32'h2, 4'hF, 0, wr, lat);
        readReg(6'h04, rd, rs);
        checkOutput("status_w1c", rd, 32'h0);
        checkOutput("irq_clear", 32'(irq), 32'd0);

        // START while busy sets ERR, no pulse
        core_busy = 1'b1;
        s0 = start_cnt;
        writeReg(6'h00, 32'h5, 4'hF, 0, wr, lat);
        checkOutput("busy_no_pulse", start_cnt - s0, 32'd0);
        readReg(6'h04, rd, rs);
        checkOutput("status_err_busy", rd, 32'h5);
        core_busy = 1'b0;
        writeReg(6'h04, 32'h4, 4'hF, 0, wr, lat);
        readReg(6'h04, rd, rs);
        checkOutput("status_err_clr", rd, 32'h0);

        // START bit ignored without byte-0 strobe
        s0 = start_cnt;
        writeReg(6'h00, 32'h1, 4'b0010, 0, wr, lat);
        checkOutput("start_nostrb", start_cnt - s0, 32'd0);

        // Sample slot: strobe check, then backpressure
        sample_ready = 1'b0;
        writeReg(6'h0C, 32'h99, 4'h7, 0, wr, lat);
        checkOutput("smp_strb_resp", 32'(wr), 32'h2);
        checkOutput("smp_strb_nopush", 32'(sample_valid), 32'd0);
        writeReg(6'h0C, 32'hA, 4'hF, 0, wr, lat);
        checkOutput("smp_a_resp", 32'(wr), 32'd0);
        checkOutput("smp_a_valid", 32'(sample_valid), 32'd1);
        checkOutput("smp_a_data", sample_data, 32'hA);
        fork
            writeReg(6'h0C, 32'hB, 4'hF, 0, wr, lat);
            begin
                repeat (4) @(negedge aclk);
                checkOutput("smp_b_stalled", 32'(bvalid), 32'd0);
                checkOutput("smp_a_held", sample_data, 32'hA);
                sample_ready = 1'b1;
                @(negedge aclk);
                sample_ready = 1'b0;
                checkOutput("smp_b_data", sample_data, 32'hB);
                checkOutput("smp_b_valid", 32'(sample_valid), 32'd1);
            end
        join
        checkOutput("smp_b_resp", 32'(wr), 32'd0);
        checkOutput("smp_b_latency", lat, 32'd4);
        sample_ready = 1'b1;
        @(negedge aclk);
        checkOutput("smp_drained", 32'(sample_valid), 32'd0);
        sample_ready = 1'b0;
        readReg(6'h0C, rd, rs);
        checkOutput("smp_read_zero", rd, 32'h0);

        // Result window and unmapped words
        readReg(6'h10, rd, rs);
        checkOutput("res0_data", rd, 32'hC0DE0000);
        checkOutput("res0_resp", 32'(rs), 32'd0);
        readReg(6'h2C, rd, rs);
        checkOutput("res7_data", rd, 32'hC0DE0007);
        readReg(6'h30, rd, rs);
        checkOutput("beyond_res_resp", 32'(rs), 32'h2);
        readReg(6'h3C, rd, rs);
        checkOutput("unmapped_rd_resp", 32'(rs), 32'h2);
        checkOutput("unmapped_rd_data", rd, 32'h0);
        writeReg(6'h10, 32'hDEAD, 4'hF, 0, wr, lat);
        checkOutput("res_wr_resp", 32'(wr), 32'h2);
        readReg(6'h10, rd, rs);
        checkOutput("res_unchanged", rd, 32'hC0DE0000);
        writeReg(6'h3C, 32'h1111, 4'hF, 0, wr, lat);
        checkOutput("unmapped_wr_resp", 32'(wr), 32'h2);
        checkOutput("unmapped_wr_cfg", core_n_samples, 32'h0000FFFF);

        // Reset in the middle of traffic
        writeReg(6'h0C, 32'hC, 4'hF, 0, wr, lat);
        pulseDone();
        @(negedge aclk);
        checkOutput("pre_rst_irq", 32'(irq), 32'd1);
        awaddr  = 6'h0C;
        awvalid = 1'b1;
        wvalid  = 1'b0;
        bready  = 1'b0;
        araddr  = 6'h08;
        arvalid = 1'b1;
        rready  = 1'b0;
        @(negedge aclk);
        awvalid = 1'b0;
        arvalid = 1'b0;
        @(negedge aclk);
        checkOutput("pre_rst_aw_held", 32'(awready), 32'd0);
        checkOutput("pre_rst_rvalid", 32'(rvalid), 32'd1);
        checkOutput("pre_rst_rdata", rdata, 32'h0000FFFF);
        aresetn = 1'b0;
        #1;
        checkOutput("mid_rst_awready", 32'(awready), 32'd0);
        checkOutput("mid_rst_wready", 32'(wready), 32'd0);
        checkOutput("mid_rst_rvalid", 32'(rvalid), 32'd0);
        checkOutput("mid_rst_rdata", rdata, 32'h0);
        checkOutput("mid_rst_smp_valid", 32'(sample_valid), 32'd0);
        checkOutput("mid_rst_smp_data", sample_data, 32'h0);
        checkOutput("mid_rst_irq", 32'(irq), 32'd0);
        checkOutput("mid_rst_cfg", core_n_samples, 32'h0);
        @(negedge aclk);
        aresetn = 1'b1;
        bready  = 1'b1;
        rready  = 1'b1;
        repeat (2) @(negedge aclk);
        writeReg(6'h08, 32'h0BADF00D, 4'hF, 0, wr, lat);
        checkOutput("post_rst_resp", 32'(wr), 32'd0);
        checkOutput("post_rst_latency", lat, 32'd1);
        readReg(6'h08, rd, rs);
        checkOutput("post_rst_cfg", rd, 32'h0BADF00D);
        checkOutput("post_rst_smp_valid", 32'(sample_valid), 32'd0);
        readReg(6'h04, rd, rs);
        checkOutput("post_rst_status", rd, 32'h0);
    endtask

    // Main sequence
    initial begin
        aresetn      = 1'b0;
        awaddr       = '0;
        awprot       = 3'b000;
        awvalid      = 1'b0;
        wdata        = '0;
        wstrb        = '0;
        wvalid       = 1'b0;
        bready       = 1'b1;
        araddr       = '0;
        arprot       = 3'b000;
        arvalid      = 1'b0;
        rready       = 1'b1;
        sample_ready = 1'b0;
        core_busy    = 1'b0;
        core_done    = 1'b0;
        for (int k = 0; k < NR; k++) begin
            core_result[32*k +: 32] = 32'hC0DE0000 + 32'(k);
        end
        repeat (3) @(negedge aclk);
        applyStimulus();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global time limit
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

endmodule
